// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BIDX_W         = 2;
    localparam int unsigned CNT_W          = 16;
    localparam logic [7:0]  CHK_INIT       = 8'h00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Append the most significant byte to the three lower bytes already held.
    function automatic logic [31:0] pack_le(input logic [23:0] lower, input logic [7:0] top);
        return {top, lower};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler with running XOR checksum.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid_c,
    output logic [31:0] word_c,
    output logic [7:0]  checksum
);

    logic [BIDX_W-1:0] byte_idx;
    logic [23:0]       low_bytes;

    // The byte that completes a word is merged directly so the word is ready on that edge.
    assign word_valid_c = byte_en && (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
    assign word_c       = pack_le(low_bytes, byte_data);

    // Shift bytes in from the top so the first byte ends up in bits 7:0; accumulate XOR.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx  <= '0;
            low_bytes <= '0;
            checksum  <= CHK_INIT;
        end else if (byte_en) begin
            byte_idx  <= byte_idx + BIDX_W'(1);
            low_bytes <= {byte_data, low_bytes[23:8]};
            checksum  <= checksum ^ byte_data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and releases the CPU from reset once the image is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(2 ** ADDR_W);

    state_t           state;
    logic [7:0]       len_lo;
    logic             len_idx;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] word_cnt;

    logic             accept_c;
    logic             start_ok_c;
    logic [CNT_W-1:0] len_c;
    logic             word_valid_c;
    logic [31:0]      word_c;
    logic [7:0]       checksum;

    // Ready depends only on state so upstream sees a stable handshake for the whole cycle.
    assign in_ready   = (state == LEN) || (state == DATA) || (state == CHK);
    assign accept_c   = in_valid && in_ready;
    assign start_ok_c = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_c      = {in_data, len_lo};

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_ok_c),
        .byte_en      (accept_c && (state == DATA)),
        .byte_data    (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c),
        .checksum     (checksum)
    );

    // Load sequencer: length, data words, checksum, then terminal DONE/ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= ADDR_W'(BASE_ADDR);
            im_wdata <= '0;
            cpu_rstn <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            len_lo   <= '0;
            len_idx  <= 1'b0;
            n_words  <= '0;
            word_cnt <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN;
                        busy     <= 1'b1;
                        cpu_rstn <= 1'b0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        len_lo   <= '0;
                        len_idx  <= 1'b0;
                        n_words  <= '0;
                        word_cnt <= '0;
                    end
                end
                LEN: begin
                    if (accept_c) begin
                        if (len_idx != 1'(LEN_BYTES - 1)) begin
                            len_lo  <= in_data;
                            len_idx <= 1'b1;
                        end else begin
                            n_words <= len_c;
                            if ({1'b0, len_c} > MAX_WORDS) begin
                                state <= ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else if (len_c == '0) begin
                                state <= CHK;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (word_valid_c) begin
                        im_we    <= 1'b1;
                        im_wdata <= word_c;
                        im_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == n_words - CNT_W'(1)) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept_c) begin
                        busy <= 1'b0;
                        if (in_data == checksum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader that streams a program image into the CPU's instruction memory, then releases the CPU from reset.
- Sits directly upstream of the single-cycle CPU and instruction memory.
- Consumes a byte stream (UART receiver or host bridge) with a valid/ready handshake.
- Assembles 32-bit words, writes them to consecutive word addresses, verifies an XOR checksum, and holds the CPU in reset until the image is verified.

Parameters:
- ADDR_W, 7, instruction-memory word-address width; capacity = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load when not busy.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word address for im_wdata.
- im_wdata  out  32  assembled word.
- cpu_rstn  out  1  active-low CPU reset; low until a verified load completes.
- busy  out  1  high in LEN, DATA, CHK.
- done  out  1  sticky; image verified.
- err  out  1  sticky; length overflow or checksum mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rstn=0, busy=0, done=0, err=0. Word counter, byte index and checksum are cleared.
- Byte transfer: a byte transfers on a rising edge where in_valid and in_ready are both high.
  - in_ready is combinational from state: 1 in LEN, DATA and CHK; 0 otherwise.
  - in_data may change freely while in_valid is low.
- States and transitions:
  - IDLE: start goes to LEN. Clears the checksum, byte index and word count, and drives cpu_rstn=0, done=0, err=0.
  - LEN: accepts 2 bytes, little-endian, forming the 16-bit word count N.
    - After the 2nd byte: if N > 2**ADDR_W, go to ERR.
    - Else if N == 0, go to CHK.
    - Else go to DATA.
  - DATA: accepts bytes little-endian (byte 0 is bits 7:0). The checksum is XOR-accumulated over every data byte.
    - On acceptance of the 4th byte of a word, the next cycle has im_we=1 with im_wdata = the assembled word and im_addr = BASE_ADDR + word index.
    - im_we is exactly 1 cycle wide.
    - Throughput is 1 byte/cycle with no stall; a write and a new byte acceptance may coincide.
    - After word N-1 is written, go to CHK.
  - CHK: accepts 1 byte.
    - If it equals the accumulated XOR, go to DONE: done=1 and cpu_rstn=1, both asserted the cycle after acceptance.
    - Otherwise go to ERR: err=1, and cpu_rstn stays 0.
  - DONE / ERR: idle with in_ready=0. start returns to LEN, and the entry actions apply: cpu_rstn, done and err all drop the next cycle.
- start rules: start in LEN, DATA or CHK is ignored. Bytes presented in IDLE, DONE or ERR are not consumed.
- Address wrap: im_addr is ADDR_W bits and wraps modulo 2**ADDR_W. Wrap is reachable only when BASE_ADDR != 0. N == 2**ADDR_W is legal.
- Reset mid-load: next state IDLE, cpu_rstn=0, and any pending im_we is suppressed. Words already written are left in memory (no rollback).
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package imem_loader_pkg contains:
  - state enum (IDLE, LEN, DATA, CHK, DONE, ERR);
  - LEN_BYTES=2;
  - BYTES_PER_WORD=4;
  - CHK_INIT=8'h00.
- Sub-module word_assembler: shift-in of bytes, 2-bit byte index, word_valid pulse, and XOR checksum. The FSM, address counter and cpu_rstn logic stay in imem_loader.

Test Plan:
- Nominal load, ADDR_W=7: start, then stream 02 00 | 13 00 00 00 | 93 00 50 00 | D0.
  - im_we pulses twice: addr 0 = 0x00000013, addr 1 = 0x00500093.
  - done=1 and cpu_rstn=1 one cycle after D0 is accepted; err=0.
- Bad checksum: same stream with final byte D1.
  - Both words are written; err=1, done=0, cpu_rstn stays 0, in_ready=0.
- Length overflow, ADDR_W=7: length bytes 81 00 (N=129).
  - ERR one cycle after the 2nd length byte; no im_we.
  - in_ready=0 while in_valid is held high.
- Zero length: 00 00 then 00.
  - DONE with no writes, cpu_rstn=1.
  - Repeat with 00 00 then 01: ERR.
- Backpressure and gaps: the nominal stream with in_valid randomly deasserted (about 50%).
  - Identical writes and order to the nominal case.
  - im_we never wider than 1 cycle.
  - start pulses during DATA are ignored.
- Reset mid-load: rst after 5 data bytes of the nominal stream.
  - Exactly one write has occurred (addr 0).
  - After reset: all outputs at reset values.
  - A fresh start plus the full nominal stream completes with done=1.
